// File: rtl/i2c_sched_pkg.sv
// Shared types for the I2C command scheduler: FSM state encoding,
// the queued request record and the fixed address/data widths of i2c_mem.
package i2c_sched_pkg;

    localparam int AW = 7;
    localparam int DW = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } sched_state_t;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } i2c_req_t;

endpackage

// File: rtl/i2c_req_fifo.sv
// Request FIFO for the I2C command scheduler. DEPTH entries of i2c_req_t,
// log2(DEPTH)-bit wrapping pointers and a separate occupancy count whose
// extra bit tells full from empty. Head entry is presented combinationally.
module i2c_req_fifo
    import i2c_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  i2c_req_t                 push_data_i,
    input  logic                     pop_i,
    output i2c_req_t                 head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    i2c_req_t      mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot, so a simultaneous push is legal even when full.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Advance pointers and track occupancy; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/i2c_cmd_sched.sv
// I2C command scheduler sitting in front of i2c_mem. Queues host requests,
// issues them one at a time on m_wr/m_addr/m_din, holds them until m_done,
// and returns exactly one in-order response per request.
// Optional feature macro: I2C_TIMEOUT_EN adds a TMO_CYC-cycle abort in S_WAIT
// that answers with rsp_err=1; without it rsp_err is tied low.
module i2c_cmd_sched
    import i2c_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 7,
    parameter int DW    = 8
`ifdef I2C_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 4095
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          busy,
    output logic          m_wr,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_din,
    input  logic [DW-1:0] m_datard,
    input  logic          m_done
);

    sched_state_t state_q;
    sched_state_t state_d;

    i2c_req_t push_req;
    i2c_req_t head_req;
    logic     fifo_full;
    logic     fifo_empty;
    logic     pop;
    logic [$clog2(DEPTH):0] fifo_count;

    logic          m_wr_q,      m_wr_d;
    logic [AW-1:0] m_addr_q,    m_addr_d;
    logic [DW-1:0] m_din_q,     m_din_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q,  rsp_data_d;
    logic          tmo_hit;

    assign push_req = '{wr: req_wr, addr: req_addr, data: req_data};

    i2c_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (req_valid && req_ready),
        .push_data_i (push_req),
        .pop_i       (pop),
        .head_o      (head_req),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Only launch a new command once the previous response has been taken.
    assign pop = (state_q == S_IDLE) && !fifo_empty && !rsp_valid_q;

`ifdef I2C_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          rsp_err_q, rsp_err_d;

    // Count cycles spent in S_WAIT; the count restarts whenever the FSM leaves it.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Expiry on the TMO_CYC-th waiting cycle; m_done in that same cycle still wins.
    assign tmo_hit = (state_q == S_WAIT) && (tmo_cnt_q == TW'(TMO_CYC - 1));

    // Error flag follows the outcome of the command that just finished.
    always_comb begin
        rsp_err_d = rsp_err_q;
        if (state_q == S_WAIT) begin
            if (m_done) begin
                rsp_err_d = 1'b0;
            end else if (tmo_hit) begin
                rsp_err_d = 1'b1;
            end
        end
    end

    // Timeout counter and error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: issue, wait for the controller, hand back the response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (m_done || tmo_hit) state_d = S_RESP;
            S_RESP:  if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
        endcase
    end

    // Output next-values: load the controller inputs on pop, capture the result on completion.
    always_comb begin
        m_wr_d      = m_wr_q;
        m_addr_d    = m_addr_q;
        m_din_d     = m_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    m_wr_d   = head_req.wr;
                    m_addr_d = head_req.addr;
                    m_din_d  = head_req.data;
                end
            end
            S_ISSUE: begin
            end
            S_WAIT: begin
                if (m_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = m_wr_q ? '0 : m_datard;
                end else if (tmo_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                end
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
        endcase
    end

    // Controller drive and response registers; m_* keep the last command between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_wr_q      <= 1'b0;
            m_addr_q    <= '0;
            m_din_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            m_wr_q      <= m_wr_d;
            m_addr_q    <= m_addr_d;
            m_din_q     <= m_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign m_wr      = m_wr_q;
    assign m_addr    = m_addr_q;
    assign m_din     = m_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign req_ready = !fifo_full;
    assign busy      = (fifo_count != '0) || (state_q != S_IDLE) || rsp_valid_q;

endmodule
